// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared state encodings, command bytes and byte-select helper
package debug_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0000,
        ST_LOAD = 4'b0001,
        ST_RUN  = 4'b0010,
        ST_STEP = 4'b0011,
        ST_DUMP = 4'b0100
    } state_t;

    typedef enum logic [1:0] {
        LD_CNT_HI,
        LD_CNT_LO,
        LD_DATA
    } load_phase_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_DUMP = 8'h44;

    // Byte idx 0 is the most significant byte of the word.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/debug_controller_if.sv
// rtl/debug_controller_if.sv - UART, instruction-memory and pipeline-debug signal bundle
interface debug_controller_if #(parameter int IMEM_AW = 8);
    logic [7:0]         i_rx_data;
    logic               i_rx_valid;
    logic [7:0]         o_tx_data;
    logic               o_tx_start;
    logic               i_tx_busy;
    logic               o_imem_we;
    logic [IMEM_AW-1:0] o_imem_addr;
    logic [7:0]         o_imem_data;
    logic               o_mips_en;
    logic               i_halt;
    logic [31:0]        i_pc;
    logic [4:0]         o_reg_sel;
    logic [31:0]        i_reg_data;
    logic [3:0]         o_state;

    modport master (
        input  i_rx_data, i_rx_valid, i_tx_busy, i_halt, i_pc, i_reg_data,
        output o_tx_data, o_tx_start, o_imem_we, o_imem_addr, o_imem_data,
               o_mips_en, o_reg_sel, o_state
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_tx_busy, i_halt, i_pc, i_reg_data,
        input  o_tx_data, o_tx_start, o_imem_we, o_imem_addr, o_imem_data,
               o_mips_en, o_reg_sel, o_state
    );
endinterface

// File: rtl/dump_serializer.sv
// rtl/dump_serializer.sv - streams PC then NREGS register words, MSB first, to the UART transmitter
module dump_serializer
    import debug_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] pc,
    input  logic [31:0] reg_data,
    input  logic        tx_busy,
    output logic [4:0]  reg_sel,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        done
);
    localparam logic [5:0] LAST_WORD = 6'(NREGS);

    logic        active;
    logic [5:0]  word_idx;
    logic [1:0]  byte_idx;
    logic [31:0] cur_word;

    // Word 0 is the PC; word k>0 is register k-1, whose select was set up one word ahead.
    assign cur_word = (word_idx == 6'd0) ? pc : reg_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            word_idx <= 6'd0;
            byte_idx <= 2'd0;
            reg_sel  <= 5'd0;
            tx_data  <= 8'd0;
            tx_start <= 1'b0;
            done     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            if (start) begin
                active   <= 1'b1;
                word_idx <= 6'd0;
                byte_idx <= 2'd0;
                reg_sel  <= 5'd0;
            end else if (active && !tx_busy && !tx_start) begin
                tx_start <= 1'b1;
                tx_data  <= word_byte(cur_word, byte_idx);
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    if (word_idx == LAST_WORD) begin
                        active <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        word_idx <= word_idx + 6'd1;
                        reg_sel  <= (word_idx == 6'd0) ? 5'd0 : word_idx[4:0];
                    end
                end
            end
        end
    end
endmodule

// File: rtl/debug_controller.sv
// rtl/debug_controller.sv - UART command FSM: program load, run/step control and state dump
module debug_controller
    import debug_pkg::*;
#(
    parameter int IMEM_AW = 8,
    parameter int NREGS   = 32
) (
    input logic               clk,
    input logic               rst,
    debug_controller_if.master bus
);
    state_t             state;
    load_phase_t        phase;
    logic [15:0]        remaining;
    logic [15:0]        count_word;
    logic [IMEM_AW-1:0] wr_addr;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [7:0]         imem_data;
    logic               dump_start;
    logic               dump_done;

    assign dump_start = (state == ST_IDLE) && bus.i_rx_valid && (bus.i_rx_data == CMD_DUMP);
    // The high count byte is parked in remaining[15:8] until the low byte arrives.
    assign count_word = {remaining[15:8], bus.i_rx_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            phase     <= LD_CNT_HI;
            remaining <= 16'd0;
            wr_addr   <= '0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_data <= 8'd0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_rx_valid) begin
                        case (bus.i_rx_data)
                            CMD_LOAD: begin
                                state <= ST_LOAD;
                                phase <= LD_CNT_HI;
                            end
                            CMD_RUN:  state <= ST_RUN;
                            CMD_STEP: state <= ST_STEP;
                            CMD_DUMP: state <= ST_DUMP;
                            default:  state <= ST_IDLE;
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (bus.i_rx_valid) begin
                        case (phase)
                            LD_CNT_HI: begin
                                remaining[15:8] <= bus.i_rx_data;
                                phase           <= LD_CNT_LO;
                            end
                            LD_CNT_LO: begin
                                remaining <= count_word;
                                if (count_word == 16'd0) begin
                                    state <= ST_IDLE;
                                    phase <= LD_CNT_HI;
                                end else begin
                                    phase <= LD_DATA;
                                end
                            end
                            default: begin
                                imem_we   <= 1'b1;
                                imem_addr <= wr_addr;
                                imem_data <= bus.i_rx_data;
                                remaining <= remaining - 16'd1;
                                if (remaining == 16'd1) begin
                                    state   <= ST_IDLE;
                                    phase   <= LD_CNT_HI;
                                    wr_addr <= '0;
                                end else begin
                                    wr_addr <= wr_addr + IMEM_AW'(1);
                                end
                            end
                        endcase
                    end
                end
                ST_RUN:  if (bus.i_halt) state <= ST_IDLE;
                ST_STEP: state <= ST_IDLE;
                ST_DUMP: if (dump_done) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    dump_serializer #(.NREGS(NREGS)) u_dump (
        .clk      (clk),
        .rst_n    (rst),
        .start    (dump_start),
        .pc       (bus.i_pc),
        .reg_data (bus.i_reg_data),
        .tx_busy  (bus.i_tx_busy),
        .reg_sel  (bus.o_reg_sel),
        .tx_data  (bus.o_tx_data),
        .tx_start (bus.o_tx_start),
        .done     (dump_done)
    );

    assign bus.o_state     = state;
    assign bus.o_mips_en   = (state == ST_RUN) || (state == ST_STEP);
    assign bus.o_imem_we   = imem_we;
    assign bus.o_imem_addr = imem_addr;
    assign bus.o_imem_data = imem_data;
endmodule

// File: tb/tb_debug_controller.sv
// tb/tb_debug_controller.sv - randomized scoreboard bench for debug_controller
module tb_debug_controller;
    import debug_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    debug_controller_if #(.IMEM_AW(8)) bus ();

    debug_controller #(.IMEM_AW(8), .NREGS(32)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    logic [31:0] regs [32];
    assign bus.i_reg_data = regs[bus.o_reg_sel];

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] exp_wr_q [$];
    logic [7:0]  exp_tx_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transmitter model: busy for 10 cycles after each start.
    int busy_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) busy_cnt = 0;
        else if (bus.o_tx_start) busy_cnt = 10;
        else if (busy_cnt > 0) busy_cnt--;
        bus.i_tx_busy = (busy_cnt > 0);
    end

    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (rst_n && bus.o_imem_we) begin
            if (exp_wr_q.size() == 0)
                check("imem_write_unexpected", {23'd0, 1'b1, bus.o_imem_addr, bus.o_imem_data}, 32'd0);
            else
                check("imem_write", {16'd0, bus.o_imem_addr, bus.o_imem_data}, {16'd0, exp_wr_q.pop_front()});
        end
        if (rst_n && bus.o_tx_start) begin
            if (exp_tx_q.size() == 0)
                check("tx_unexpected", {23'd0, 1'b1, bus.o_tx_data}, 32'd0);
            else
                check("tx_byte(backtoback,data)", {23'd0, prev_start, bus.o_tx_data}, {24'd0, exp_tx_q.pop_front()});
        end
        prev_start = bus.o_tx_start;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int c = 0;
        while (bus.o_state !== 4'b0000 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, {28'd0, bus.o_state}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"},     {28'd0, bus.o_state}, 32'd0);
        check({tag, "_ctl"},       {29'd0, bus.o_tx_start, bus.o_imem_we, bus.o_mips_en}, 32'd0);
        check({tag, "_data"},      {8'd0, bus.o_tx_data, bus.o_imem_addr, bus.o_imem_data}, 32'd0);
        check({tag, "_reg_sel"},   {27'd0, bus.o_reg_sel}, 32'd0);
    endtask

    function automatic logic [7:0] rand_non_cmd();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255));
        while (b == CMD_LOAD || b == CMD_RUN || b == CMD_STEP || b == CMD_DUMP);
        return b;
    endfunction

    // abort_after < 0: complete load; otherwise reset is pulsed before data byte abort_after.
    task automatic do_load(input logic [7:0] data [$], input int abort_after);
        int          n  = data.size();
        logic [15:0] nn = 16'(n);
        logic [7:0]  d;
        send_byte(CMD_LOAD, $urandom_range(0, 2));
        send_byte(nn[15:8], $urandom_range(0, 2));
        send_byte(nn[7:0], (n == 0) ? 0 : $urandom_range(0, 2));
        for (int i = 0; i < n; i++) begin
            d = data[i];
            if (i == abort_after) begin
                #2 rst_n = 1'b0;
                #1 check_all_zero("abort");
                @(negedge clk);
                rst_n = 1'b1;
            end
            if (abort_after >= 0 && i >= abort_after) d = rand_non_cmd();
            else exp_wr_q.push_back({i[7:0], d});
            send_byte(d, (i == n - 1) ? 0 : $urandom_range(0, 2));
        end
        check("load_end_state", {28'd0, bus.o_state}, 32'd0);
        repeat (2) @(negedge clk);
        check("load_writes_left", exp_wr_q.size(), 0);
    endtask

    task automatic do_dump(input logic [31:0] pc, input logic [31:0] reg1);
        bus.i_pc = pc;
        for (int r = 0; r < 32; r++) regs[r] = $urandom;
        regs[1] = reg1;
        for (int k = 3; k >= 0; k--) exp_tx_q.push_back(8'(pc >> (8 * k)));
        for (int r = 0; r < 32; r++)
            for (int k = 3; k >= 0; k--) exp_tx_q.push_back(8'(regs[r] >> (8 * k)));
        send_byte(CMD_DUMP, 1);
        send_byte(CMD_LOAD, 2);
        wait_idle(4000, "dump_idle");
        repeat (15) @(negedge clk);
        check("dump_bytes_left", exp_tx_q.size(), 0);
        check("dump_state_after", {28'd0, bus.o_state}, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q [$];
        int cnt, rises, n;
        logic prev;

        rst_n          = 1'b0;
        bus.i_rx_data  = 8'd0;
        bus.i_rx_valid = 1'b0;
        bus.i_halt     = 1'b0;
        bus.i_pc       = 32'd0;
        for (int r = 0; r < 32; r++) regs[r] = 32'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Non-command bytes in IDLE are ignored.
        for (int i = 0; i < 6; i++) send_byte(rand_non_cmd(), $urandom_range(0, 2));
        check("ignore_state", {28'd0, bus.o_state}, 32'd0);

        q = '{8'h85, 8'h08, 8'h00, 8'h00};
        do_load(q, -1);
        q = {};
        do_load(q, -1);
        for (int t = 0; t < 3; t++) begin
            q = {};
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            do_load(q, -1);
        end
        q = {};
        for (int i = 0; i < 260; i++) q.push_back(8'($urandom));
        do_load(q, -1);

        // RUN: halt raised after 10 enabled cycles.
        send_byte(CMD_RUN, 0);
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            if (bus.o_mips_en) cnt++;
            if (cnt == 10) bus.i_halt = 1'b1;
            if (!bus.o_mips_en && cnt > 0) break;
            @(negedge clk);
        end
        check("run_en_cycles", cnt, 10);
        check("run_end_state", {28'd0, bus.o_state}, 32'd0);
        check("run_en_low", {31'd0, bus.o_mips_en}, 32'd0);

        // RUN entered with halt already high still gives one enable cycle.
        send_byte(CMD_RUN, 0);
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.o_mips_en) cnt++;
            @(negedge clk);
        end
        check("run_halted_en_cycles", cnt, 1);
        bus.i_halt = 1'b0;

        cnt = 0; rises = 0; prev = 1'b0;
        for (int k = 0; k < 2; k++) begin
            send_byte(CMD_STEP, 0);
            for (int c = 0; c < 6; c++) begin
                if (bus.o_mips_en && !prev) rises++;
                if (bus.o_mips_en) cnt++;
                prev = bus.o_mips_en;
                @(negedge clk);
            end
        end
        check("step_en_cycles", cnt, 2);
        check("step_en_pulses", rises, 2);

        do_dump(32'h0000_000C, 32'hDEAD_BEEF);
        do_dump($urandom, $urandom);

        q = {};
        for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
        do_load(q, 2);
        check("abort_state_after", {28'd0, bus.o_state}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/debug_controller.md
DEBUG_CONTROLLER -- requirements
Module: debug_controller

Interface
REQ-001 The block SHALL have parameter IMEM_AW, default 8, instruction-memory byte-address width.
REQ-002 The block SHALL have parameter NREGS, default 32, number of register-file words dumped.
REQ-003 The block SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst  in  1  reset; asynchronous and active-low.
REQ-005 The block SHALL have port i_rx_data  in  8  received UART byte.
REQ-006 The block SHALL have port i_rx_valid  in  1  one-cycle strobe; i_rx_data valid.
REQ-007 The block SHALL have port o_tx_data  out  8  byte to transmit.
REQ-008 The block SHALL have port o_tx_start  out  1  one-cycle transmit request.
REQ-009 The block SHALL have port i_tx_busy  in  1  transmitter busy; rises the cycle after o_tx_start.
REQ-010 The block SHALL have port o_imem_we  out  1  instruction-memory byte write enable.
REQ-011 The block SHALL have port o_imem_addr  out  IMEM_AW  instruction-memory byte address.
REQ-012 The block SHALL have port o_imem_data  out  8  instruction-memory write byte.
REQ-013 The block SHALL have port o_mips_en  out  1  pipeline clock enable.
REQ-014 The block SHALL have port i_halt  in  1  pipeline reached HALT.
REQ-015 The block SHALL have port i_pc  in  32  current PC.
REQ-016 The block SHALL have port o_reg_sel  out  5  register-file read select.
REQ-017 The block SHALL have port i_reg_data  in  32  selected register value, combinational from o_reg_sel.
REQ-018 The block SHALL have port o_state  out  4  current FSM state.

Function
REQ-019 FSM states SHALL be IDLE=4'b0000, LOAD=4'b0001, RUN=4'b0010, STEP=4'b0011, DUMP=4'b0100.
REQ-020 In IDLE, an i_rx_valid byte SHALL select the next state: 0x4C 'L'→LOAD, 0x52 'R'→RUN, 0x53 'S'→STEP, 0x44 'D'→DUMP; any other byte is ignored.
REQ-021 LOAD SHALL take a 16-bit big-endian byte count N from the next two rx bytes, then write the next N rx bytes to addresses 0,1,…, wrapping modulo 2^IMEM_AW.
REQ-022 Each LOAD data byte SHALL produce o_imem_we=1 for exactly one cycle, the cycle after its i_rx_valid, with o_imem_addr/o_imem_data registered.
REQ-023 N=0 SHALL return to IDLE the cycle after the second count byte, with no writes.
REQ-024 After the N-th write, the FSM SHALL return to IDLE and reset the write address to 0.
REQ-025 o_mips_en SHALL be 1 only in RUN or STEP; STEP SHALL last exactly one cycle, then go to IDLE.
REQ-026 RUN SHALL go to IDLE on the first cycle i_halt=1 is sampled, giving at least one enable cycle if i_halt is already high on entry.
REQ-027 rx bytes received in RUN, STEP or DUMP SHALL be ignored.
REQ-028 DUMP SHALL send 4+4*NREGS bytes, MSB first: i_pc, then registers 0..NREGS-1 via o_reg_sel.
REQ-029 o_tx_start SHALL pulse only when i_tx_busy=0 and no start was issued the previous cycle; o_tx_data SHALL be stable during the pulse.
REQ-030 After the last dump byte's start pulse, the FSM SHALL return to IDLE.

Reset
REQ-031 While rst=0, the block SHALL hold state IDLE, counters 0, and o_tx_start, o_imem_we, o_mips_en at 0.
REQ-032 While rst=0, o_tx_data, o_imem_addr, o_imem_data and o_reg_sel SHALL be 0.
REQ-033 An active reset in any state SHALL abort the operation immediately with no further writes or starts.

Structure
REQ-034 A shared package debug_pkg SHALL hold state encodings and command byte constants.
REQ-035 The DUMP byte sequencing (word/byte counters, start handshake) SHALL be the sub-module dump_serializer.

Verification
REQ-036 Send 'L',0x00,0x04,0x85,0x08,0x00,0x00 → four o_imem_we pulses at addresses 0..3 with those bytes, then IDLE.
REQ-037 Send 'L',0x00,0x00 → no o_imem_we; o_state=0000 the next cycle.
REQ-038 Send 'R', raise i_halt 10 cycles later → o_mips_en high for 10 cycles, low after, o_state=0000.
REQ-039 Send 'S' twice → o_mips_en high for exactly two separated single cycles.
REQ-040 i_pc=0x0000000C, reg1=0xDEADBEEF, send 'D', model i_tx_busy 10 cycles per byte → 132 bytes, starting 00 00 00 0C, bytes 9..12 = DE AD BE EF.
REQ-041 Pull rst low mid-LOAD after 2 of 4 data bytes → outputs zero at once, o_state=0000, later bytes cause no writes.
